// File: rtl/pod_mem_pkg.sv
// Shared definitions for the pod memory controller: FSM states, host command
// codes, default widths and the command-to-state decode.
package pod_mem_pkg;

    localparam int D_W_DEF    = 64;
    localparam int ADDR_W_DEF = 14;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_LOAD  = 2'b01,
        ST_RUN   = 2'b10,
        ST_DRAIN = 2'b11
    } state_t;

    localparam logic [1:0] CMD_RSVD  = 2'b00;
    localparam logic [1:0] CMD_LOAD  = 2'b01;
    localparam logic [1:0] CMD_RUN   = 2'b10;
    localparam logic [1:0] CMD_DRAIN = 2'b11;

    // State entered when a legal command is accepted in IDLE.
    function automatic state_t cmd_to_state(input logic [1:0] cmd);
        state_t st;
        case (cmd)
            CMD_LOAD:  st = ST_LOAD;
            CMD_RUN:   st = ST_RUN;
            CMD_DRAIN: st = ST_DRAIN;
            default:   st = ST_IDLE;
        endcase
        return st;
    endfunction

endpackage

// File: rtl/pod_ram.sv
// Simple dual-port pod RAM: one write port, one read port, read data
// registered one cycle after rd_en_i. A same-address read and write in one
// cycle returns the old contents; callers forward if they need new data.
module pod_ram #(
    parameter int D_W    = 64,
    parameter int ADDR_W = 14
) (
    input  logic              clk,
    input  logic              wr_en_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [D_W-1:0]    wr_data_i,
    input  logic              rd_en_i,
    input  logic [ADDR_W-1:0] rd_addr_i,
    output logic [D_W-1:0]    rd_data_o
);

    logic [D_W-1:0] mem_q [2**ADDR_W];
    logic [D_W-1:0] rd_data_q;

    // Storage write and registered read.
    // NOTE: non-blocking (<=) for all sequential state so every flop samples
    // pre-edge values; blocking here would make the read see the new write.
    // NOTE: the array has no reset; a reset would need a per-word sweep and the
    // contents are required to survive rst.
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
        if (rd_en_i) begin
            rd_data_q <= mem_q[rd_addr_i];
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/pod_mem_ctrl.sv
// Pod memory controller: host LOAD of weights, RUN-time weight reads with
// write-first forwarding of PE results, and DRAIN of results through a
// 2-entry output buffer with valid/ready handshake.
module pod_mem_ctrl
    import pod_mem_pkg::*;
#(
    parameter int D_W    = D_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    input  logic [1:0]        cmd,
    input  logic              ld_valid,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [D_W-1:0]    ld_data,
    input  logic              ld_last,
    input  logic [ADDR_W-1:0] weight_addr,
    output logic [D_W-1:0]    weight,
    input  logic              pe_wr_en,
    input  logic [ADDR_W-1:0] in_pod_addr,
    input  logic [D_W-1:0]    in_pod_data,
    input  logic              run_stop,
    input  logic [ADDR_W-1:0] drain_base,
    input  logic [ADDR_W:0]   drain_len,
    output logic [D_W-1:0]    dr_data,
    output logic              dr_valid,
    input  logic              dr_ready,
    output logic              busy,
    output logic              err_cmd
);

    state_t state_q;
    logic   err_cmd_q;

    // Command decode
    logic cmd_accept, cmd_illegal, drain_start;
    assign cmd_accept  = cmd_valid && (state_q == ST_IDLE) && (cmd != CMD_RSVD);
    assign cmd_illegal = cmd_valid && ((state_q != ST_IDLE) || (cmd == CMD_RSVD));
    assign drain_start = cmd_accept && (cmd == CMD_DRAIN);

    // RAM write port: LOAD and PE writes never overlap since they live in
    // different states; reset blocks any write in its cycle.
    logic              load_wr, pe_wr, ram_wr_en;
    logic [ADDR_W-1:0] ram_wr_addr;
    logic [D_W-1:0]    ram_wr_data;
    assign load_wr     = (state_q == ST_LOAD) && ld_valid;
    assign pe_wr       = (state_q == ST_RUN) && pe_wr_en;
    assign ram_wr_en   = !rst && (load_wr || pe_wr);
    assign ram_wr_addr = load_wr ? ld_addr : in_pod_addr;
    assign ram_wr_data = load_wr ? ld_data : in_pod_data;

    // Drain bookkeeping
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d, rd_addr_cur;
    logic [ADDR_W:0]   rd_left_q, rd_left_d, rd_left_cur;
    logic [ADDR_W:0]   tx_left_q, tx_left_d;
    logic              inflight_q;
    logic [D_W-1:0]    buf_q [2];
    logic              buf_wr_ptr_q, buf_rd_ptr_q;
    logic [1:0]        buf_cnt_q, buf_cnt_d;
    logic              pop, drain_rd, drain_done;

    assign dr_valid = (buf_cnt_q != 2'd0);
    assign dr_data  = buf_q[buf_rd_ptr_q];
    assign pop      = (state_q == ST_DRAIN) && dr_valid && dr_ready;

    // Occupancy after this cycle's arrival and transfer; a new read is only
    // issued while that leaves room for it, which sustains one word per cycle.
    assign buf_cnt_d = buf_cnt_q + {1'b0, inflight_q} - {1'b0, pop};

    // The first drain read goes out in the command cycle straight from the
    // command fields, so the first word is buffered two cycles later.
    assign rd_addr_cur = (state_q == ST_DRAIN) ? rd_addr_q : drain_base;
    assign rd_left_cur = (state_q == ST_DRAIN) ? rd_left_q : drain_len;
    assign drain_rd    = (drain_start || ((state_q == ST_DRAIN) && (buf_cnt_d < 2'd2)))
                         && (rd_left_cur != '0);
    assign drain_done  = (state_q == ST_DRAIN) &&
                         ((tx_left_q == '0) || (pop && (tx_left_q == (ADDR_W+1)'(1))));

    // RAM read port: RUN weight reads, otherwise drain reads.
    logic              run_rd, ram_rd_en;
    logic [ADDR_W-1:0] ram_rd_addr;
    logic [D_W-1:0]    ram_rd_data;
    assign run_rd      = (state_q == ST_RUN);
    assign ram_rd_en   = run_rd || drain_rd;
    assign ram_rd_addr = run_rd ? weight_addr : rd_addr_cur;

    pod_ram #(
        .D_W    (D_W),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk       (clk),
        .wr_en_i   (ram_wr_en),
        .wr_addr_i (ram_wr_addr),
        .wr_data_i (ram_wr_data),
        .rd_en_i   (ram_rd_en),
        .rd_addr_i (ram_rd_addr),
        .rd_data_o (ram_rd_data)
    );

    // Control FSM with registered error pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            err_cmd_q <= 1'b0;
        end else begin
            err_cmd_q <= cmd_illegal;
            case (state_q)
                ST_IDLE:  if (cmd_accept)           state_q <= cmd_to_state(cmd);
                ST_LOAD:  if (ld_valid && ld_last)  state_q <= ST_IDLE;
                ST_RUN:   if (run_stop)             state_q <= ST_IDLE;
                ST_DRAIN: if (drain_done)           state_q <= ST_IDLE;
                default:                            state_q <= ST_IDLE;
            endcase
        end
    end

    assign busy    = (state_q != ST_IDLE);
    assign err_cmd = err_cmd_q;

    // Next-state for drain address and word counters.
    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        rd_addr_d = rd_addr_q;
        rd_left_d = rd_left_q;
        tx_left_d = tx_left_q;
        if (drain_start) begin
            rd_addr_d = drain_base;
            rd_left_d = drain_len;
            tx_left_d = drain_len;
        end
        if (drain_rd) begin
            rd_addr_d = rd_addr_cur + ADDR_W'(1);
            rd_left_d = rd_left_cur - (ADDR_W+1)'(1);
        end
        if (pop) begin
            tx_left_d = tx_left_q - (ADDR_W+1)'(1);
        end
    end

    // Drain counters, in-flight flag and the 2-entry output buffer.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_addr_q    <= '0;
            rd_left_q    <= '0;
            tx_left_q    <= '0;
            inflight_q   <= 1'b0;
            buf_q[0]     <= '0;
            buf_q[1]     <= '0;
            buf_wr_ptr_q <= 1'b0;
            buf_rd_ptr_q <= 1'b0;
            buf_cnt_q    <= 2'd0;
        end else begin
            rd_addr_q  <= rd_addr_d;
            rd_left_q  <= rd_left_d;
            tx_left_q  <= tx_left_d;
            inflight_q <= drain_rd;
            if (inflight_q) begin
                buf_q[buf_wr_ptr_q] <= ram_rd_data;
                buf_wr_ptr_q        <= ~buf_wr_ptr_q;
            end
            if (pop) begin
                buf_rd_ptr_q <= ~buf_rd_ptr_q;
            end
            buf_cnt_q <= buf_cnt_d;
        end
    end

    // Weight path: RAM data after a RUN read, forwarded PE data on a
    // same-address write, otherwise the last value held.
    logic           run_rd_q, fwd_q;
    logic [D_W-1:0] fwd_data_q, weight_hold_q;

    assign weight = !run_rd_q ? weight_hold_q :
                    (fwd_q    ? fwd_data_q    : ram_rd_data);

    // Weight tracking registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            run_rd_q      <= 1'b0;
            fwd_q         <= 1'b0;
            fwd_data_q    <= '0;
            weight_hold_q <= '0;
        end else begin
            run_rd_q      <= run_rd;
            fwd_q         <= pe_wr && (in_pod_addr == weight_addr);
            fwd_data_q    <= in_pod_data;
            weight_hold_q <= weight;
        end
    end

endmodule

// File: tb/tb_pod_mem_ctrl.sv
// Directed bench for pod_mem_ctrl: reference memory model plus a drain
// scoreboard queue filled at command time and emptied on each transfer.
module tb_pod_mem_ctrl;
    import pod_mem_pkg::*;

    localparam int D_W   = 64;
    localparam int AW    = 6;
    localparam int DEPTH = 2**AW;

    logic          clk = 1'b0;
    logic          rst;
    logic          cmd_valid;
    logic [1:0]    cmd;
    logic          ld_valid;
    logic [AW-1:0] ld_addr;
    logic [D_W-1:0] ld_data;
    logic          ld_last;
    logic [AW-1:0] weight_addr;
    logic [D_W-1:0] weight;
    logic          pe_wr_en;
    logic [AW-1:0] in_pod_addr;
    logic [D_W-1:0] in_pod_data;
    logic          run_stop;
    logic [AW-1:0] drain_base;
    logic [AW:0]   drain_len;
    logic [D_W-1:0] dr_data;
    logic          dr_valid;
    logic          dr_ready;
    logic          busy;
    logic          err_cmd;

    pod_mem_ctrl #(.D_W(D_W), .ADDR_W(AW)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd(cmd),
        .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_data(ld_data), .ld_last(ld_last),
        .weight_addr(weight_addr), .weight(weight), .pe_wr_en(pe_wr_en),
        .in_pod_addr(in_pod_addr), .in_pod_data(in_pod_data), .run_stop(run_stop),
        .drain_base(drain_base), .drain_len(drain_len), .dr_data(dr_data),
        .dr_valid(dr_valid), .dr_ready(dr_ready), .busy(busy), .err_cmd(err_cmd)
    );

    always #5 clk = ~clk;

    int             n_vec = 0;
    int             n_err = 0;
    logic [D_W-1:0] model_mem [DEPTH];
    logic [D_W-1:0] sb_q [$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic send_cmd(input logic [1:0] c);
        cmd_valid = 1'b1;
        cmd       = c;
        cyc();
        cmd_valid = 1'b0;
        cmd       = 2'b00;
    endtask

    task automatic load_word(input int addr, input logic [D_W-1:0] data, input logic last);
        ld_valid = 1'b1;
        ld_addr  = addr[AW-1:0];
        ld_data  = data;
        ld_last  = last;
        cyc();
        model_mem[addr] = data;
        ld_valid = 1'b0;
        ld_last  = 1'b0;
    endtask

    // mode 0: always ready, 1: ready toggles 1/0, other: random ready.
    task automatic drain(input int base, input int len, input int mode);
        int             cycles;
        logic           stalled;
        logic [D_W-1:0] held;
        for (int i = 0; i < len; i++) sb_q.push_back(model_mem[(base + i) % DEPTH]);
        cmd_valid  = 1'b1;
        cmd        = CMD_DRAIN;
        drain_base = base[AW-1:0];
        drain_len  = len[AW:0];
        dr_ready   = 1'b0;
        cyc();
        cmd_valid  = 1'b0;
        check("drain_busy", busy, 1);
        check("drain_c1_no_valid", dr_valid, 0);
        if (len == 0) begin
            cyc();
            check("drain0_idle", busy, 0);
            check("drain0_no_valid", dr_valid, 0);
            return;
        end
        cyc();
        check("drain_first_valid", dr_valid, 1);
        stalled = 1'b0;
        held    = '0;
        cycles  = 0;
        while (sb_q.size() != 0 && cycles < len * 4 + 20) begin
            case (mode)
                0:       dr_ready = 1'b1;
                1:       dr_ready = ((cycles % 2) == 0);
                default: dr_ready = 1'($urandom_range(0, 1));
            endcase
            if (stalled) begin
                check("drain_stall_valid", dr_valid, 1);
                check("drain_stall_data", dr_data, held);
            end
            if (dr_valid && dr_ready) check("drain_data", dr_data, sb_q.pop_front());
            stalled = dr_valid && !dr_ready;
            held    = dr_data;
            cyc();
            cycles++;
        end
        dr_ready = 1'b0;
        check("drain_all_words", sb_q.size(), 0);
        sb_q.delete();
        check("drain_end_idle", busy, 0);
        check("drain_end_no_valid", dr_valid, 0);
        if (mode == 0) check("drain_throughput_cycles", cycles, len);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; cmd_valid = 1'b0; cmd = 2'b00;
        ld_valid = 1'b0; ld_addr = '0; ld_data = '0; ld_last = 1'b0;
        weight_addr = '0; pe_wr_en = 1'b0; in_pod_addr = '0; in_pod_data = '0;
        run_stop = 1'b0; drain_base = '0; drain_len = '0; dr_ready = 1'b0;
        cyc();
        cyc();
        check("rst_busy", busy, 0);
        check("rst_weight", weight, 0);
        check("rst_dr_valid", dr_valid, 0);
        check("rst_dr_data", dr_data, 0);
        check("rst_err_cmd", err_cmd, 0);
        rst = 1'b0;

        // Fill the whole memory; every fifth slot is a bubble carrying a
        // stray ld_last that must be ignored without ld_valid.
        send_cmd(CMD_LOAD);
        check("load_busy", busy, 1);
        for (int i = 0; i < DEPTH; i++) begin
            if ((i % 5) == 4) begin
                ld_valid = 1'b0; ld_last = 1'b1; ld_data = 64'hBAD0_BAD0_BAD0_BAD0;
                cyc();
                ld_last = 1'b0;
                check("load_bubble_busy", busy, 1);
            end
            load_word(i, 64'hC0DE_0000_0000_0000 | (64'(i) * 64'h0001_0001), i == DEPTH - 1);
        end
        check("load_last_idle", busy, 0);

        send_cmd(CMD_LOAD);
        for (int i = 0; i < 4; i++) load_word(i, 64'(i + 1), 1'b0);
        load_word(5, 64'hA5, 1'b0);
        load_word(63, 64'hFEED_FACE_CAFE_F00D, 1'b1);
        check("load2_idle", busy, 0);
        check("weight_zero_before_run", weight, 0);

        // RUN: reads, forwarding, illegal command, stop with write.
        send_cmd(CMD_RUN);
        check("run_busy", busy, 1);
        weight_addr = 5; cyc();
        check("run_rd5", weight, 64'hA5);
        weight_addr = 0; cyc();
        check("run_rd0", weight, model_mem[0]);
        pe_wr_en = 1'b1; in_pod_addr = 7; in_pod_data = 64'h1234; weight_addr = 7;
        cyc();
        pe_wr_en = 1'b0; model_mem[7] = 64'h1234;
        check("run_fwd", weight, 64'h1234);
        weight_addr = 7; cyc();
        check("run_rd_after_wr", weight, model_mem[7]);
        pe_wr_en = 1'b1; in_pod_addr = 8; in_pod_data = 64'hBEEF_0008; weight_addr = 9;
        cyc();
        pe_wr_en = 1'b0; model_mem[8] = 64'hBEEF_0008;
        check("run_other_addr", weight, model_mem[9]);
        weight_addr = 8; cyc();
        check("run_rd8", weight, model_mem[8]);
        cmd_valid = 1'b1; cmd = CMD_LOAD; weight_addr = 5;
        cyc();
        cmd_valid = 1'b0;
        check("illegal_err", err_cmd, 1);
        check("illegal_stays_run", busy, 1);
        check("illegal_weight", weight, 64'hA5);
        weight_addr = 3; cyc();
        check("illegal_err_one_cycle", err_cmd, 0);
        check("illegal_still_run", busy, 1);
        check("illegal_next_weight", weight, model_mem[3]);
        run_stop = 1'b1; pe_wr_en = 1'b1; in_pod_addr = 10; in_pod_data = 64'h5707_0010;
        weight_addr = 10;
        cyc();
        run_stop = 1'b0; pe_wr_en = 1'b0; model_mem[10] = 64'h5707_0010;
        check("stop_idle", busy, 0);
        check("stop_fwd", weight, model_mem[10]);

        // IDLE: weight holds and PE writes are ignored.
        pe_wr_en = 1'b1; in_pod_addr = 11; in_pod_data = 64'hDEAD_0011; weight_addr = 5;
        cyc();
        pe_wr_en = 1'b0;
        check("idle_weight_hold", weight, model_mem[10]);

        send_cmd(CMD_RSVD);
        check("rsvd_err", err_cmd, 1);
        check("rsvd_idle", busy, 0);
        cyc();
        check("rsvd_err_one_cycle", err_cmd, 0);

        drain(0, 4, 1);
        drain(DEPTH - 1, 2, 0);
        drain(10, 3, 0);
        drain(0, 0, 0);

        // Reset mid-LOAD and mid-RUN: no write may land in the reset cycle.
        send_cmd(CMD_LOAD);
        rst = 1'b1; ld_valid = 1'b1; ld_addr = 20; ld_data = 64'hDEAD_0020;
        cyc();
        rst = 1'b0; ld_valid = 1'b0;
        check("rst_load_idle", busy, 0);
        check("rst_load_weight", weight, 0);
        send_cmd(CMD_RUN);
        weight_addr = 5; cyc();
        check("run2_rd5", weight, 64'hA5);
        rst = 1'b1; pe_wr_en = 1'b1; in_pod_addr = 12; in_pod_data = 64'hDEAD_0012;
        weight_addr = 12;
        cyc();
        rst = 1'b0; pe_wr_en = 1'b0;
        check("rst_run_idle", busy, 0);
        check("rst_run_weight", weight, 0);
        drain(10, 11, 2);

        // Reset in DRAIN after one of four transfers, then restart.
        cmd_valid = 1'b1; cmd = CMD_DRAIN; drain_base = 0; drain_len = 4; dr_ready = 1'b0;
        cyc();
        cmd_valid = 1'b0;
        cyc();
        check("rstdr_first_valid", dr_valid, 1);
        check("rstdr_first_data", dr_data, model_mem[0]);
        dr_ready = 1'b1;
        cyc();
        rst = 1'b1; dr_ready = 1'b0;
        cyc();
        rst = 1'b0;
        check("rstdr_no_valid", dr_valid, 0);
        check("rstdr_idle", busy, 0);
        check("rstdr_data_zero", dr_data, 0);
        drain(0, 4, 0);

        // Full-memory drains, wrapping once.
        drain(17, DEPTH, 2);
        drain(0, DEPTH, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
